alu_pipe: RTL

Parametrised, pipelined successor to the team's gate-level 8-bit ALU/parity benchmark circuit.
- Performs one WIDTH-bit arithmetic/logic operation per accepted transaction.
- Returns result plus carry, zero and parity flags through a two-stage registered pipeline with valid/ready handshakes on both sides.
- Sits between an operand source (pattern player or datapath sequencer) and a result sink/scoreboard.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_core.sv | 56 +++++
 rtl/alu_pipe.sv | 102 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, flag and width definitions for the pipelined ALU.
package alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_PASS = 3'd5,
    OP_INC  = 3'd6,
    OP_CMP  = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic parity;
  } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: one operation on WIDTH-bit unsigned operands,
// with optional saturation and carry/zero/parity flags.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit SAT_EN = 1'b0
) (
  input  alu_op_e            op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   result,
  output alu_flags_t         flags
);

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH:0]   inc_ext;
  logic [WIDTH-1:0] raw;
  logic             carry;

  always_comb begin
    sum_ext  = {1'b0, a} + {1'b0, b};
    diff_ext = {1'b0, a} - {1'b0, b};
    inc_ext  = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
    raw      = '0;
    carry    = 1'b0;

    // Bit WIDTH of the extended difference is the unsigned borrow (A < B).
    case (op)
      OP_ADD:  begin raw = sum_ext[WIDTH-1:0];  carry = sum_ext[WIDTH];  end
      OP_SUB:  begin raw = diff_ext[WIDTH-1:0]; carry = diff_ext[WIDTH]; end
      OP_AND:  raw = a & b;
      OP_OR:   raw = a | b;
      OP_XOR:  raw = a ^ b;
      OP_PASS: raw = a;
      OP_INC:  begin raw = inc_ext[WIDTH-1:0];  carry = inc_ext[WIDTH];  end
      OP_CMP:  begin raw = '0;                  carry = diff_ext[WIDTH]; end
      default: begin raw = '0;                  carry = 1'b0;            end
    endcase

    result = raw;
    if (SAT_EN && carry) begin
      if (op == OP_ADD || op == OP_INC) begin
        result = '1;
      end else if (op == OP_SUB) begin
        result = '0;
      end
    end

    flags.carry  = carry;
    flags.zero   = (op == OP_CMP) ? (a == b) : (result == '0);
    flags.parity = ^result;
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage ALU pipeline: S1 registers operands, S2 registers result and
// flags; valid/ready handshakes on both sides with full-rate throughput.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit SAT_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  alu_op_e          in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_parity
);

  logic             s1_valid_q, s1_valid_d;
  alu_op_e          s1_op_q, s1_op_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_result_q, s2_result_d;
  alu_flags_t       s2_flags_q, s2_flags_d;

  logic             s2_adv;
  logic             in_fire;
  logic             s1_fire;
  logic [WIDTH-1:0] core_result;
  alu_flags_t       core_flags;

  alu_core #(
    .WIDTH  (WIDTH),
    .SAT_EN (SAT_EN)
  ) u_core (
    .op     (s1_op_q),
    .a      (s1_a_q),
    .b      (s1_b_q),
    .result (core_result),
    .flags  (core_flags)
  );

  // S2 frees up when empty or draining; S1 may refill in the same cycle it advances.
  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    in_ready = !s1_valid_q || s2_adv;
    in_fire  = in_valid && in_ready;
    s1_fire  = s1_valid_q && s2_adv;

    s1_op_d     = s1_op_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s2_result_d = s2_result_q;
    s2_flags_d  = s2_flags_q;

    s1_valid_d = in_fire || (s1_valid_q && !s2_adv);
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;

    if (in_fire) begin
      s1_op_d = in_op;
      s1_a_d  = in_a;
      s1_b_d  = in_b;
    end
    if (s1_fire) begin
      s2_result_d = core_result;
      s2_flags_d  = core_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= OP_ADD;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_flags_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_flags_q  <= s2_flags_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = s2_result_q;
  assign out_carry  = s2_flags_q.carry;
  assign out_zero   = s2_flags_q.zero;
  assign out_parity = s2_flags_q.parity;

endmodule
